// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential restoring divider. One quotient bit per cycle,
//                MSB first, on operand magnitudes, followed by a single
//                sign-fix cycle. Divide-by-zero short-cuts to the result
//                stage and flags div_err.
//                Optional signed support is enabled by defining the macro
//                DIV_SEQ_SIGNED_EN; without it is_signed is ignored and
//                every operation is unsigned (ovf stays 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    output logic [bits-1:0] div,
    output logic [bits-1:0] mod,
    output logic            busy,
    output logic            ready,
    output logic            div_err,
    output logic            ovf
);

`ifdef DIV_SEQ_SIGNED_EN
    localparam logic C_SIGNED_EN = 1'b1;
`else
    localparam logic C_SIGNED_EN = 1'b0;
`endif

    localparam int                 C_CNT_W   = $clog2(bits + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = 1;
    localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'(bits - 1);
    localparam logic [bits-1:0]    C_MIN     = {1'b1, {(bits-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched operands and mode (held for the whole operation)
    logic [bits-1:0]    a_q, a_d;
    logic [bits-1:0]    b_q, b_d;
    logic               sgn_q, sgn_d;
    // Working registers: divisor magnitude, partial remainder, quotient
    logic [bits-1:0]    dvs_q, dvs_d;
    logic [bits-1:0]    rem_q, rem_d;
    logic [bits-1:0]    quo_q, quo_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    // Visible result registers
    logic [bits-1:0]    div_q, div_d;
    logic [bits-1:0]    mod_q, mod_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    // One restoring step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits. The shifted value may need
    // bits+1 bits, but any accepted difference always fits in bits.
    logic [bits:0]      w_shift;
    logic               w_ge;
    logic [bits-1:0]    w_sub;

    assign w_shift = {rem_q, quo_q[bits-1]};
    assign w_ge    = (w_shift >= {1'b0, dvs_q});
    assign w_sub   = w_shift[bits-1:0] - dvs_q;

    // Magnitude of an operand; the most negative value maps onto 2^(bits-1)
    function automatic logic [bits-1:0] f_mag(input logic [bits-1:0] x,
                                              input logic            s);
        f_mag = (s && x[bits-1]) ? -x : x;
    endfunction

    // Next-state logic of the control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (b == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == C_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: operand capture, iteration, sign fix, result load
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mod_d   = mod_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    sgn_d = C_SIGNED_EN & is_signed;
                    dvs_d = f_mag(b, C_SIGNED_EN & is_signed);
                    quo_d = f_mag(a, C_SIGNED_EN & is_signed);
                    rem_d = '0;
                    cnt_d = '0;
                end
            end
            S_CALC: begin
                quo_d = {quo_q[bits-2:0], w_ge};
                rem_d = w_ge ? w_sub : w_shift[bits-1:0];
                cnt_d = cnt_q + C_CNT_ONE;
            end
            S_FIX: begin
                // Quotient truncates toward zero, remainder follows a
                if (sgn_q && (a_q[bits-1] ^ b_q[bits-1])) begin
                    quo_d = -quo_q;
                end
                if (sgn_q && a_q[bits-1]) begin
                    rem_d = -rem_q;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                if (b_q == '0) begin
                    div_d = '1;
                    mod_d = a_q;
                    err_d = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    div_d = quo_q;
                    mod_d = rem_q;
                    err_d = 1'b0;
                    // MIN / -1 naturally yields MIN and 0; only flag it
                    ovf_d = sgn_q && (a_q == C_MIN) && (b_q == '1);
                end
            end
            default: ;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            mod_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign ready   = ready_q;
    assign div     = div_q;
    assign mod     = mod_q;
    assign div_err = err_q;
    assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq (bits = 8). Expected
//                results come from a behavioural model and are queued when
//                an operation is started, then popped when ready pulses.
//                Signed expectations follow DIV_SEQ_SIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    localparam int BITS = 8;
`ifdef DIV_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
        logic       ovf;
    } res_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic       is_signed = 1'b0;
    logic [7:0] a         = '0;
    logic [7:0] b         = '0;
    logic [7:0] div;
    logic [7:0] mod;
    logic       busy;
    logic       ready;
    logic       div_err;
    logic       ovf;

    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    div_seq #(.bits(BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .div       (div),
        .mod       (mod),
        .busy      (busy),
        .ready     (ready),
        .div_err   (div_err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic s);
        res_t r;
        int   sx;
        int   sy;
        r = '0;
        if (y == 8'd0) begin
            r.q   = 8'hFF;
            r.r   = x;
            r.err = 1'b1;
        end else if (s && SIGNED_EN) begin
            sx = $signed(x);
            sy = $signed(y);
            if (sx == -128 && sy == -1) begin
                r.q   = 8'h80;
                r.r   = 8'h00;
                r.ovf = 1'b1;
            end else begin
                r.q = 8'(sx / sy);
                r.r = 8'(sx % sy);
            end
        end else begin
            r.q = x / y;
            r.r = x % y;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse across the next edge and queue its expectation
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s);
        a         = x;
        b         = y;
        is_signed = s;
        start     = 1'b1;
        sb_q.push_back(model(x, y, s));
        tick();
        start     = 1'b0;
    endtask

    // Edges counted until ready is seen; -1 when the bound expires
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pop_exp(output res_t e);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else                 e = '1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({div, mod, busy, ready, div_err, ovf} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0",
                     {div, mod, busy, ready, div_err, ovf});
        end
        reset = 1'b1;
    endtask

    task automatic test_unsigned();
        res_t e;
        int   n;
        issue(8'd100, 8'd7, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start: got %b required 1", busy);
        end
        checks++;
        if (div !== 8'd0) begin
            errors++; $display("FAIL div_held_during_calc: got %h required 00", div);
        end
        wait_ready(n);
        checks++;
        if (n !== 10) begin
            errors++; $display("FAIL latency_100_7: got %0d required 10", n);
        end
        pop_exp(e);
        checks++;
        if ({div, mod, div_err, ovf} !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
            errors++; $display("FAIL result_100_7: got %h/%h e%b o%b required 0e/02 e0 o0",
                               div, mod, div_err, ovf);
        end
        checks++;
        if ({div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL model_100_7: got %h required %h", {div, mod, div_err, ovf}, e);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_after_done: got %b required 0", busy);
        end
        tick();
        checks++;
        if ({ready, div, mod} !== {1'b0, 8'd14, 8'd2}) begin
            errors++; $display("FAIL ready_pulse_hold: got %h required 00e02", {ready, div, mod});
        end
    endtask

    task automatic test_signed();
        logic [7:0] xs[4] = '{8'hF9, 8'h07, 8'h9C, 8'h64};
        logic [7:0] ys[4] = '{8'h02, 8'hFE, 8'h07, 8'hF9};
        res_t e;
        int   n;
        for (int i = 0; i < 4; i++) begin
            issue(xs[i], ys[i], 1'b1);
            wait_ready(n);
            pop_exp(e);
            checks++;
            if (n !== 10 || {div, mod, div_err, ovf} !== e) begin
                errors++;
                $display("FAIL signed_%0d: got lat %0d res %h required lat 10 res %h",
                         i, n, {div, mod, div_err, ovf}, e);
            end
        end
    endtask

    task automatic test_div_zero();
        res_t e;
        int   n;
        issue(8'h37, 8'h00, 1'b0);
        wait_ready(n);
        checks++;
        if (n !== 1) begin
            errors++; $display("FAIL latency_div0: got %0d required 1", n);
        end
        pop_exp(e);
        checks++;
        if ({div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL result_div0: got %h required %h", {div, mod, div_err, ovf}, e);
        end
        issue(8'd50, 8'd5, 1'b0);
        wait_ready(n);
        pop_exp(e);
        checks++;
        if (n !== 10 || {div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL clear_div_err: got lat %0d res %h required lat 10 res %h",
                               n, {div, mod, div_err, ovf}, e);
        end
    endtask

    task automatic test_overflow();
        res_t e;
        int   n;
        for (int s = 1; s >= 0; s--) begin
            issue(8'h80, 8'hFF, s[0]);
            wait_ready(n);
            pop_exp(e);
            checks++;
            if (n !== 10 || {div, mod, div_err, ovf} !== e) begin
                errors++; $display("FAIL overflow_s%0d: got lat %0d res %h required lat 10 res %h",
                                   s, n, {div, mod, div_err, ovf}, e);
            end
        end
    endtask

    task automatic test_ignore_start();
        res_t e;
        int   n;
        int   pulses;
        issue(8'd200, 8'd9, 1'b0);
        tick(); tick(); tick();
        start = 1'b1; a = 8'h11; b = 8'h22; is_signed = 1'b1;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00; is_signed = 1'b0;
        wait_ready(n);
        pop_exp(e);
        checks++;
        if (n !== 6 || {div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL ignore_start: got lat %0d res %h required lat 6 res %h",
                               n, {div, mod, div_err, ovf}, e);
        end
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL no_extra_result: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        res_t e;
        int   n;
        issue(8'd123, 8'd4, 1'b0);
        pop_exp(e);
        tick(); tick(); tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({div, mod, busy, ready, div_err, ovf} !== 22'd0) begin
            errors++; $display("FAIL reset_mid_calc: got %h required 0",
                               {div, mod, busy, ready, div_err, ovf});
        end
        tick();
        tick();
        reset = 1'b1;
        issue(8'd45, 8'd6, 1'b0);
        wait_ready(n);
        pop_exp(e);
        checks++;
        if (n !== 10 || {div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL after_reset_op: got lat %0d res %h required lat 10 res %h",
                               n, {div, mod, div_err, ovf}, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t       e;
        int         n;
        logic [7:0] x;
        logic [7:0] y;
        logic       s;
        issue(8'd250, 8'd3, 1'b0);
        wait_ready(n);
        pop_exp(e);
        checks++;
        if (n !== 10 || {div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL b2b_first: got lat %0d res %h required lat 10 res %h",
                               n, {div, mod, div_err, ovf}, e);
        end
        issue(8'd77, 8'd8, 1'b0);
        wait_ready(n);
        pop_exp(e);
        checks++;
        if (n + 1 !== BITS + 3 || {div, mod, div_err, ovf} !== e) begin
            errors++; $display("FAIL b2b_spacing: got gap %0d res %h required gap %0d res %h",
                               n + 1, {div, mod, div_err, ovf}, BITS + 3, e);
        end
        for (int i = 0; i < 12; i++) begin
            x = 8'($urandom_range(0, 255));
            y = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            issue(x, y, s);
            wait_ready(n);
            pop_exp(e);
            checks++;
            if (n !== ((y == 8'd0) ? 1 : 10) || {div, mod, div_err, ovf} !== e) begin
                errors++; $display("FAIL random_%0d: %h/%h s%b got lat %0d res %h required res %h",
                                   i, x, y, s, n, {div, mod, div_err, ovf}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_empty: got %0d left required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
